// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 3;
    localparam int CONV_ITERS = 10;   // one shift per accumulator bit
    localparam int MAX_BIN    = 255;
    localparam int DIGIT_MAX  = 9;
    localparam int ACC_W      = 10;   // wide enough for 999
    localparam int CNT_W      = 4;

    // True when a 4-bit code is not a legal decimal digit.
    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of reverse double dabble: after the right
// shift, any digit of 8 or more picked up a borrowed 10 as 16, so take 3 off.
module bcd_digit_adjust (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Subtract 3 from digits >= 8, pass smaller digits through.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential 3-digit BCD to binary converter (reverse double dabble),
// one bit per clock, saturating at 255 with an overflow flag.
module bcd_to_binary #(
    parameter int NUM_DIGITS = bcd_pkg::NUM_DIGITS,
    parameter int BIN_WIDTH  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           hundreds,
    input  logic [3:0]           tens,
    input  logic [3:0]           ones,
    output logic [BIN_WIDTH-1:0] binary,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 error
);

    import bcd_pkg::state_t;
    import bcd_pkg::IDLE;
    import bcd_pkg::CONVERT;
    import bcd_pkg::DONE;
    import bcd_pkg::CONV_ITERS;
    import bcd_pkg::MAX_BIN;
    import bcd_pkg::ACC_W;
    import bcd_pkg::CNT_W;
    import bcd_pkg::digit_bad;

    localparam int                BCD_W     = 4 * NUM_DIGITS;
    localparam logic [ACC_W-1:0]  MAX_ACC   = ACC_W'(MAX_BIN);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(CONV_ITERS - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [BIN_WIDTH-1:0] bin_q, bin_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    logic [BCD_W-1:0]       digits_in;
    logic                   in_bad;
    logic [BCD_W+ACC_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_sh, bcd_adj;
    logic [ACC_W-1:0]       acc_sh;

    assign digits_in = {hundreds, tens, ones};
    assign in_bad    = digit_bad(hundreds) | digit_bad(tens) | digit_bad(ones);

    // One iteration: shift the BCD/accumulator pair right by one bit.
    assign shifted = {bcd_q, acc_q} >> 1;
    assign bcd_sh  = shifted[BCD_W+ACC_W-1:ACC_W];
    assign acc_sh  = shifted[ACC_W-1:0];

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (bcd_sh[4*g +: 4]),
                .digit_o (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // State, datapath and result registers; reset clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath control; results hold unless updated.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Digits are captured here so later input changes are harmless.
                    bcd_d = digits_in;
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    if (in_bad) begin
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = CONVERT;
                    end
                end
            end
            CONVERT: begin
                bcd_d = bcd_adj;
                acc_d = acc_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    // Last shift: accumulator now holds the full decimal value.
                    cnt_d   = '0;
                    state_d = DONE;
                    if (acc_sh > MAX_ACC) begin
                        bin_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        bin_d = acc_sh[BIN_WIDTH-1:0];
                        ovf_d = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == CONVERT);
    assign done     = (state_q == DONE);
    assign binary   = bin_q;
    assign overflow = ovf_q;
    assign error    = err_q;

endmodule
